ws2812_decoder: RTL and testbench

Receive-side WS2812 single-wire decoder: samples an incoming WS2812 data line and classifies each high pulse as a 0 or 1 bit. It assembles 24-bit GRB pixels MSB-first and flags frame ends from the reset (latch) gap. It sits at the board input, feeding the pixel buffer and loopback-checking the transmit path, and optionally regenerates the downstream chain like a real LED.

---
 rtl/ws2812_defs.sv | 29 ++
 rtl/ws2812_edge_sync.sv | 33 +++
 rtl/ws2812_decoder.sv | 175 +++++++++++++++++
 tb/tb_ws2812_decoder.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ws2812_defs.sv
// Shared WS2812 definitions: default bit timing at a 200 MHz system clock,
// pixel width, counter width and decoder state encodings. The transmitter
// takes its bit timing from this package as well.
`timescale 1ns/100ps

package ws2812_defs;

  // Pulse-width limits and frame gap, in 200 MHz clock cycles
  localparam int CNT_HIGH_MIN   = 2*10;
  localparam int CNT_BIT_THRESH = 2*85;
  localparam int CNT_HIGH_MAX   = 2*200;
  localparam int CNT_RESET      = 2*5000;

  localparam int PIXEL_W = 24;
  localparam int CNT_W   = 16;

  typedef logic [1:0] ws_state_t;

  // Kept as plain constants so older state-machine code can use the same encodings
  localparam ws_state_t ST_GAP  = 2'd0;
  localparam ws_state_t ST_LOW  = 2'd1;
  localparam ws_state_t ST_HIGH = 2'd2;

  // Width counters stick at all-ones instead of wrapping
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/ws2812_edge_sync.sv
// Brings the asynchronous WS2812 line into the clock domain with two flops,
// keeps one more delayed copy, and derives single-cycle rise/fall strobes.
`timescale 1ns/100ps

module ws2812_edge_sync (
  input  logic clk_in,
  input  logic rst_n_in,
  input  logic ws2812_data_in,
  output logic din_s,
  output logic rise,
  output logic fall
);

  logic din_meta;
  logic din_d;

  // Two-stage synchronizer followed by the delay stage used for edge detection
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      din_meta <= 1'b0;
      din_s    <= 1'b0;
      din_d    <= 1'b0;
    end else begin
      din_meta <= ws2812_data_in;
      din_s    <= din_meta;
      din_d    <= din_s;
    end
  end

  assign rise = din_s & ~din_d;
  assign fall = ~din_s & din_d;

endmodule

// File: rtl/ws2812_decoder.sv
// WS2812 receive decoder: measures each high pulse on the synchronized line,
// turns it into a 0/1 bit, packs 24 bits MSB-first into a GRB pixel and marks
// frame ends from the long low latch gap. Illegal pulse widths abort the
// frame and decoding waits for the next full gap.
// Optional build macro WS2812_DECODER_FWD_EN: regenerates the line for the
// next device in the chain with the first pixel of each frame stripped off.
`timescale 1ns/100ps

module ws2812_decoder #(
  parameter int CNT_HIGH_MIN   = ws2812_defs::CNT_HIGH_MIN,
  parameter int CNT_BIT_THRESH = ws2812_defs::CNT_BIT_THRESH,
  parameter int CNT_HIGH_MAX   = ws2812_defs::CNT_HIGH_MAX,
  parameter int CNT_RESET      = ws2812_defs::CNT_RESET
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        ws2812_data_in,
  output logic [23:0] pixel_data_out,
  output logic        pixel_vld_out,
  output logic        frame_done_out,
  output logic        err_out,
  output logic        ws2812_data_out
);

  import ws2812_defs::*;

  localparam logic [CNT_W-1:0] HIGH_MIN_C = CNT_W'(CNT_HIGH_MIN);
  localparam logic [CNT_W-1:0] THRESH_C   = CNT_W'(CNT_BIT_THRESH);
  localparam logic [CNT_W-1:0] HIGH_MAX_C = CNT_W'(CNT_HIGH_MAX);
  localparam logic [CNT_W-1:0] RESET_C    = CNT_W'(CNT_RESET);

  logic             din_s;
  logic             rise;
  logic             fall;
  logic [CNT_W-1:0] high_cnt;
  logic [CNT_W-1:0] low_cnt;
  ws_state_t        state;
  logic [4:0]       bit_idx;
  logic [23:0]      shift_q;
  logic             bits_seen;

  logic             bit_val;
  logic [23:0]      shift_next;
  logic             frame_end_evt;
  logic             err_evt;
  logic             bit_evt;
  logic             pix_evt;

  ws2812_edge_sync u_edge_sync (
    .clk_in         (clk_in),
    .rst_n_in       (rst_n_in),
    .ws2812_data_in (ws2812_data_in),
    .din_s          (din_s),
    .rise           (rise),
    .fall           (fall)
  );

  // The count seen on the fall cycle is exactly the synchronized high width
  assign bit_val       = (high_cnt > THRESH_C);
  assign shift_next    = {shift_q[22:0], bit_val};
  assign frame_end_evt = (state == ST_LOW) && (low_cnt == RESET_C);
  assign err_evt       = (state == ST_HIGH) &&
                         ((fall && (high_cnt < HIGH_MIN_C)) || (high_cnt > HIGH_MAX_C));
  assign bit_evt       = (state == ST_HIGH) && fall &&
                         (high_cnt >= HIGH_MIN_C) && (high_cnt <= HIGH_MAX_C);
  assign pix_evt       = bit_evt && (bit_idx == 5'd23);

  // High and low width counters, each cleared by the edge that ends the other level
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      high_cnt <= '0;
      low_cnt  <= '0;
    end else begin
      if (fall) begin
        high_cnt <= '0;
      end else if (din_s) begin
        high_cnt <= sat_inc(high_cnt);
      end
      if (rise) begin
        low_cnt <= '0;
      end else if (!din_s) begin
        low_cnt <= sat_inc(low_cnt);
      end
    end
  end

  // Frame state machine, bit assembly and the registered output strobes
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state          <= ST_GAP;
      bit_idx        <= '0;
      shift_q        <= '0;
      bits_seen      <= 1'b0;
      pixel_data_out <= '0;
      pixel_vld_out  <= 1'b0;
      frame_done_out <= 1'b0;
      err_out        <= 1'b0;
    end else begin
      pixel_vld_out  <= 1'b0;
      frame_done_out <= 1'b0;
      err_out        <= 1'b0;
      case (state)
        ST_GAP: begin
          if (low_cnt == RESET_C) begin
            bit_idx   <= '0;
            shift_q   <= '0;
            bits_seen <= 1'b0;
            state     <= rise ? ST_HIGH : ST_LOW;
          end
        end
        ST_LOW: begin
          if (frame_end_evt) begin
            frame_done_out <= bits_seen;
            bits_seen      <= 1'b0;
            bit_idx        <= '0;
            shift_q        <= '0;
          end
          if (rise) begin
            state <= ST_HIGH;
          end
        end
        ST_HIGH: begin
          if (err_evt) begin
            err_out   <= 1'b1;
            bits_seen <= 1'b0;
            bit_idx   <= '0;
            shift_q   <= '0;
            state     <= ST_GAP;
          end else if (bit_evt) begin
            shift_q   <= shift_next;
            bits_seen <= 1'b1;
            state     <= ST_LOW;
            if (pix_evt) begin
              pixel_data_out <= shift_next;
              pixel_vld_out  <= 1'b1;
              bit_idx        <= '0;
            end else begin
              bit_idx <= bit_idx + 5'd1;
            end
          end
        end
        default: begin
          state <= ST_GAP;
        end
      endcase
    end
  end

`ifdef WS2812_DECODER_FWD_EN
  logic fwd_active;

  // Forwarding window opens after the first pixel and closes at frame end or error
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      fwd_active <= 1'b0;
    end else if (frame_end_evt || err_evt) begin
      fwd_active <= 1'b0;
    end else if (pix_evt) begin
      fwd_active <= 1'b1;
    end
  end

  // Regenerated downstream line, gated copy of the synchronized input
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      ws2812_data_out <= 1'b0;
    end else begin
      ws2812_data_out <= din_s & fwd_active;
    end
  end
`else
  assign ws2812_data_out = 1'b0;
`endif

endmodule

// File: tb/tb_ws2812_decoder.sv
// Self-checking bench for ws2812_decoder: table of whole-frame vectors with
// expected pulse counts and pixel values, plus hand-written sequences for
// reset mid-frame, decoding without an initial gap, and line forwarding.
// The latch gap is shortened to 600 cycles so the run stays short; every bit
// low time used here stays far below it, and all width limits keep defaults.
`timescale 1ns/100ps

module tb_ws2812_decoder;

  localparam int RST_GAP = 600;

`ifdef WS2812_DECODER_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk_in = 1'b0;
  logic        rst_n_in = 1'b0;
  logic        ws2812_data_in = 1'b0;
  logic [23:0] pixel_data_out;
  logic        pixel_vld_out;
  logic        frame_done_out;
  logic        err_out;
  logic        ws2812_data_out;

  int checks = 0;
  int errors = 0;

  int vldCount = 0;
  int fdCount = 0;
  int errCount = 0;
  int overlapCount = 0;
  logic [23:0] pixQ[$];

  bit   fwdCheckOn = 1'b0;
  int   fwdBad = 0;
  int   fwdHigh = 0;
  logic lineElig = 1'b0;
  logic [2:0] hLine = '0;
  logic [2:0] hElig = '0;
  logic fwdExp;

  typedef struct {
    logic [47:0] bits;
    int          nBits;
    int          p0;
    int          w0;
    int          p1;
    int          w1;
    bit          plan;
    int          expVld;
    logic [23:0] expPixel;
    int          expFd;
    int          expErr;
  } vec_t;

  vec_t vecs[6];

  always #2.5 clk_in = ~clk_in;

  ws2812_decoder #(.CNT_RESET(RST_GAP)) dut (
    .clk_in          (clk_in),
    .rst_n_in        (rst_n_in),
    .ws2812_data_in  (ws2812_data_in),
    .pixel_data_out  (pixel_data_out),
    .pixel_vld_out   (pixel_vld_out),
    .frame_done_out  (frame_done_out),
    .err_out         (err_out),
    .ws2812_data_out (ws2812_data_out)
  );

  // Line history: after each edge, hLine[2] is the level the DUT should be forwarding now
  always @(posedge clk_in) begin
    hLine <= {hLine[1:0], ws2812_data_in};
    hElig <= {hElig[1:0], lineElig};
  end

  // Output monitor sampling on the falling edge
  always @(negedge clk_in) begin
    if (rst_n_in) begin
      if (pixel_vld_out) begin
        vldCount++;
        pixQ.push_back(pixel_data_out);
      end
      if (frame_done_out) fdCount++;
      if (err_out) errCount++;
      if (pixel_vld_out && frame_done_out) overlapCount++;
      if (fwdCheckOn) begin
        fwdExp = FWD ? (hLine[2] & hElig[2]) : 1'b0;
        if (ws2812_data_out !== fwdExp) fwdBad++;
        if (ws2812_data_out === 1'b1) fwdHigh++;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic driveLevel(input logic val, input int n);
    ws2812_data_in = val;
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic sendBit(input logic b, input int hiW, input bit plan, input bit elig);
    int hi;
    int lo;
    hi = (hiW > 0) ? hiW : (b ? 270 : 70);
    lo = plan ? (b ? 70 : 180) : 40;
    lineElig = elig;
    driveLevel(1'b1, hi);
    lineElig = 1'b0;
    driveLevel(1'b0, lo);
  endtask

  task automatic sendBits(input logic [47:0] bits, input int n, input int p0, input int w0,
                          input int p1, input int w1, input bit plan, input int eligFrom);
    for (int i = 0; i < n; i++) begin
      int w;
      w = (i == p0) ? w0 : ((i == p1) ? w1 : 0);
      sendBit(bits[n-1-i], w, plan, i >= eligFrom);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    sendBits(v.bits, v.nBits, v.p0, v.w0, v.p1, v.w1, v.plan, 99);
    driveLevel(1'b0, RST_GAP + 8);
  endtask

  initial begin
    int b0;
    int f0;
    int e0;
    int expHigh;
    logic [47:0] fwdBits;
    logic [23:0] pA;
    logic [23:0] pB;

    vecs[0] = '{48'hA53CF0, 24, -1, 0, -1, 0, 1'b1, 1, 24'hA53CF0, 1, 0};
    vecs[1] = '{{18'd0, 24'h3C5A96, 6'b101101}, 30, -1, 0, -1, 0, 1'b0, 1, 24'h3C5A96, 1, 0};
    vecs[2] = '{{41'd0, 7'b1010110}, 7, 3, 19, -1, 0, 1'b0, 0, 24'h3C5A96, 0, 1};
    vecs[3] = '{{41'd0, 7'b1010110}, 7, 3, 401, -1, 0, 1'b0, 0, 24'h3C5A96, 0, 1};
    vecs[4] = '{{24'd0, 24'h4B1E2D}, 24, 0, 170, 1, 171, 1'b0, 1, 24'h4B1E2D, 1, 0};
    vecs[5] = '{{24'd0, 24'h69C387}, 24, 0, 20, 1, 400, 1'b0, 1, 24'h69C387, 1, 0};

    // Reset values
    driveLevel(1'b0, 4);
    checkOutput("reset_pixel", {8'd0, pixel_data_out}, 32'd0);
    checkOutput("reset_vld", {31'd0, pixel_vld_out}, 32'd0);
    checkOutput("reset_fd", {31'd0, frame_done_out}, 32'd0);
    checkOutput("reset_err", {31'd0, err_out}, 32'd0);
    checkOutput("reset_fwd", {31'd0, ws2812_data_out}, 32'd0);
    rst_n_in = 1'b1;
    driveLevel(1'b0, RST_GAP + 8);

    // Table-driven frames
    for (int v = 0; v < 6; v++) begin
      b0 = vldCount;
      f0 = fdCount;
      e0 = errCount;
      applyStimulus(vecs[v]);
      checkOutput($sformatf("vec%0d_vld", v), vldCount - b0, vecs[v].expVld);
      checkOutput($sformatf("vec%0d_fd", v), fdCount - f0, vecs[v].expFd);
      checkOutput($sformatf("vec%0d_err", v), errCount - e0, vecs[v].expErr);
      checkOutput($sformatf("vec%0d_pixel", v), {8'd0, pixel_data_out}, {8'd0, vecs[v].expPixel});
    end

    // Reset in the middle of a frame clears every output at once
    sendBits({24'd0, 24'hF0F0F0}, 12, -1, 0, -1, 0, 1'b0, 99);
    rst_n_in = 1'b0;
    #0.5;
    checkOutput("midrst_pixel", {8'd0, pixel_data_out}, 32'd0);
    checkOutput("midrst_vld", {31'd0, pixel_vld_out}, 32'd0);
    checkOutput("midrst_fd", {31'd0, frame_done_out}, 32'd0);
    checkOutput("midrst_err", {31'd0, err_out}, 32'd0);
    checkOutput("midrst_fwd", {31'd0, ws2812_data_out}, 32'd0);
    driveLevel(1'b0, 3);
    rst_n_in = 1'b1;

    // Bits straight out of reset without a gap must be ignored
    b0 = vldCount;
    f0 = fdCount;
    e0 = errCount;
    sendBits({18'd0, 24'hB5E34C, 6'b110011}, 30, -1, 0, -1, 0, 1'b0, 99);
    driveLevel(1'b0, RST_GAP + 8);
    checkOutput("nogap_vld", vldCount - b0, 0);
    checkOutput("nogap_fd", fdCount - f0, 0);
    checkOutput("nogap_err", errCount - e0, 0);

    b0 = vldCount;
    f0 = fdCount;
    sendBits({24'd0, 24'hD27E81}, 24, -1, 0, -1, 0, 1'b0, 99);
    driveLevel(1'b0, RST_GAP + 8);
    checkOutput("postrst_vld", vldCount - b0, 1);
    checkOutput("postrst_pixel", {8'd0, pixel_data_out}, {8'd0, 24'hD27E81});
    checkOutput("postrst_fd", fdCount - f0, 1);

    // 48-bit frame: two pixels decoded, second half forwarded when enabled
    fwdBits = {24'h5AC30F, 24'h96E1A7};
    expHigh = 0;
    for (int i = 24; i < 48; i++) begin
      if (FWD) expHigh += fwdBits[47-i] ? 270 : 70;
    end
    b0 = vldCount;
    f0 = fdCount;
    fwdBad = 0;
    fwdHigh = 0;
    fwdCheckOn = 1'b1;
    sendBits(fwdBits, 48, -1, 0, -1, 0, 1'b0, 24);
    driveLevel(1'b0, RST_GAP + 8);
    fwdCheckOn = 1'b0;
    pA = (pixQ.size() >= 2) ? pixQ[pixQ.size()-2] : 24'd0;
    pB = (pixQ.size() >= 1) ? pixQ[pixQ.size()-1] : 24'd0;
    checkOutput("fwd_vld", vldCount - b0, 2);
    checkOutput("fwd_pixel_first", {8'd0, pA}, {8'd0, 24'h5AC30F});
    checkOutput("fwd_pixel_second", {8'd0, pB}, {8'd0, 24'h96E1A7});
    checkOutput("fwd_fd", fdCount - f0, 1);
    checkOutput("fwd_bad_cycles", fwdBad, 0);
    checkOutput("fwd_high_cycles", fwdHigh, expHigh);

    checkOutput("vld_fd_overlap", overlapCount, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
